// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register file's single write port between NREQ sources.
// Optional: define REGFILE_WB_FIXED_PRIO_EN for fixed priority (index 0 highest).
module regfile_wb_arbiter #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_rd,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [4:0]           wr_rd,
    output logic [31:0]          wr_data,
    output logic [2:0]           wr_src,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_found;
    logic             xfer;
    logic             stall;
    logic [4:0]       gnt_rd;
    logic [31:0]      gnt_data;

`ifndef REGFILE_WB_FIXED_PRIO_EN
    logic [PTR_W-1:0] ptr;
`endif

    // Scan requesters starting at the pointer (or at 0 for fixed priority).
    always_comb begin
        automatic int idx;
        gnt_idx   = '0;
        gnt_found = 1'b0;
        for (int k = 0; k < int'(NREQ); k++) begin
`ifdef REGFILE_WB_FIXED_PRIO_EN
            idx = k;
`else
            idx = int'(ptr) + k;
            if (idx >= int'(NREQ)) begin
                idx = idx - int'(NREQ);
            end
`endif
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && !wb_hold && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        xfer     = |req_ready;
        gnt_rd   = req_rd[5*int'(gnt_idx) +: 5];
        gnt_data = req_data[32*int'(gnt_idx) +: 32];
        // Contention: some valid requester was not served this cycle.
        stall    = $countones(req_valid) > (xfer ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_rd     <= '0;
            wr_data   <= '0;
            wr_src    <= '0;
            stall_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            if (xfer) begin
                wr_rd   <= gnt_rd;
                wr_data <= gnt_data;
                wr_src  <= 3'(gnt_idx);
                wr_en   <= |gnt_rd;
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

`ifndef REGFILE_WB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end
`endif

endmodule
